alu_response_tx: RTL and testbench

Serial response transmitter for the serial ALU link: it is the producing end of the result stream that the testbench monitor deserialises and the scoreboard checks. It captures one result (32-bit C plus flags) or one error indication per handshake, and shifts it out on a single line as 11-bit frames. A data response is four data frames carrying C, then a control frame with flags and CRC3. An error response is a single error control frame.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_frame_shifter.sv | 47 ++++
 rtl/alu_response_tx.sv | 163 ++++++++++++++++
 tb/tb_alu_response_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types, constants and helpers for the serial ALU link.
// Holds frame format, error-flag type, CRC3 and error-payload functions.
package alu_pkg;

  typedef enum logic {
    DATA = 1'b0,
    CTL  = 1'b1
  } frame_type_t;

  typedef logic [2:0] err_flags_t;

  localparam int FRAME_LEN   = 11;
  localparam int DATA_FRAMES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_DATA,
    S_LOAD_ERR,
    S_SHIFT,
    S_GAP
  } tx_state_t;

  // Serial CRC, poly x^3+x+1, MSB of d first.
  function automatic logic [2:0] nextCRC3_D37(
    input logic [36:0] d,
    input logic [2:0]  c
  );
    logic [2:0] r;
    logic       fb;
    r = c;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ d[i];
      r  = {r[1], r[0] ^ fb, fb};
    end
    return r;
  endfunction

  // {1, e[5:0], p}: only the highest set flag survives,
  // no flag at all reads as ERR_OP; p makes the byte even.
  function automatic logic [7:0] err_payload(
    input err_flags_t f
  );
    logic [2:0] one;
    logic [5:0] e;
    if (f[2])      one = 3'b100;
    else if (f[1]) one = 3'b010;
    else           one = 3'b001;
    e = {one, one};
    return {1'b1, e, ^{1'b1, e}};
  endfunction

endpackage

// File: rtl/alu_frame_shifter.sv
// alu_frame_shifter: 11-bit frame serialiser, MSB first, idles at 1.
// Ports: clk, rst, i_load, i_type, i_byte -> o_sout, o_frame_end.
module alu_frame_shifter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  frame_type_t i_type,
  input  logic [7:0]  i_byte,
  output logic        o_sout,
  output logic        o_frame_end
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] r_sh;
  logic [3:0]           r_cnt;
  logic                 r_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '1;
      r_cnt <= '0;
      r_act <= 1'b0;
    end else if (i_load) begin
      r_sh  <= {1'b0, i_type, i_byte, 1'b1};
      r_cnt <= '0;
      r_act <= 1'b1;
    end else begin
      // ones shift in behind the frame, so the line idles high
      r_sh <= {r_sh[FRAME_LEN-2:0], 1'b1};
      if (r_act) begin
        if (r_cnt == LAST_BIT) begin
          r_act <= 1'b0;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  assign o_sout      = r_sh[FRAME_LEN-1];
  assign o_frame_end = r_act && (r_cnt == LAST_BIT);

endmodule

// File: rtl/alu_response_tx.sv
// alu_response_tx: serial response transmitter (4 data + CRC ctl frame,
// or one error ctl frame). Ports: clk, rst, tx_valid/tx_ready, tx_err,
// tx_c, tx_flags, tx_err_flags -> sout, tx_done.
// ALU_TX_GAP_EN: two idle bits between frames of a data response.
module alu_response_tx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_err,
  input  logic [31:0] tx_c,
  input  logic [3:0]  tx_flags,
  input  logic [2:0]  tx_err_flags,
  output logic        sout,
  output logic        tx_done
);

`ifdef ALU_TX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [2:0] CTL_IDX = 3'(DATA_FRAMES);

  tx_state_t   r_state;
  tx_state_t   w_next;
  logic [31:0] r_c;
  logic [3:0]  r_flags;
  logic [2:0]  r_frm;
  logic        r_gap;
  logic        r_done;

  logic        w_fend;
  logic        w_more;
  logic [2:0]  w_crc;
  logic [2:0]  w_nfrm;
  logic [7:0]  w_nbyte;
  frame_type_t w_ntype;
  logic        w_load;
  frame_type_t w_type;
  logic [7:0]  w_byte;
  logic        w_end;

  assign w_more = (r_frm != CTL_IDX);
  assign w_nfrm = r_frm + 3'd1;
  assign w_crc  = nextCRC3_D37({r_c, 1'b0, r_flags}, 3'b000);

  always_comb begin
    w_nbyte = {1'b0, r_flags, w_crc};
    w_ntype = CTL;
    unique case (w_nfrm)
      3'd1: begin w_nbyte = r_c[23:16]; w_ntype = DATA; end
      3'd2: begin w_nbyte = r_c[15:8];  w_ntype = DATA; end
      3'd3: begin w_nbyte = r_c[7:0];   w_ntype = DATA; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (tx_valid)
          w_next = tx_err ? S_LOAD_ERR : S_LOAD_DATA;
      end
      S_LOAD_ERR: begin
        if (w_fend) w_next = S_IDLE;
      end
      S_LOAD_DATA, S_SHIFT: begin
        if (w_fend) begin
          if (!w_more)     w_next = S_IDLE;
          else if (GAP_EN) w_next = S_GAP;
          else             w_next = S_SHIFT;
        end
      end
      S_GAP: begin
        if (r_gap) w_next = S_SHIFT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    w_load   = 1'b0;
    w_type   = DATA;
    w_byte   = '0;
    w_end    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_load = 1'b1;
          w_type = tx_err ? CTL : DATA;
          w_byte = tx_err ? err_payload(tx_err_flags)
                          : tx_c[31:24];
        end
      end
      S_LOAD_ERR: w_end = w_fend;
      S_LOAD_DATA, S_SHIFT: begin
        if (w_fend) begin
          if (!w_more) begin
            w_end = 1'b1;
          end else if (!GAP_EN) begin
            w_load = 1'b1;
            w_type = w_ntype;
            w_byte = w_nbyte;
          end
        end
      end
      S_GAP: begin
        if (r_gap) begin
          w_load = 1'b1;
          w_type = w_ntype;
          w_byte = w_nbyte;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c     <= '0;
      r_flags <= '0;
      r_frm   <= '0;
      r_gap   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_end;
      // r_gap is 0 on entry to S_GAP: two idle bit times
      r_gap  <= (r_state == S_GAP) ? ~r_gap : 1'b0;
      if (r_state == S_IDLE && tx_valid) begin
        r_c     <= tx_c;
        r_flags <= tx_flags;
        r_frm   <= '0;
      end else if (w_load) begin
        r_frm <= w_nfrm;
      end
    end
  end

  assign tx_done = r_done;

  alu_frame_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_type      (w_type),
    .i_byte      (w_byte),
    .o_sout      (sout),
    .o_frame_end (w_fend)
  );

endmodule

// File: tb/tb_alu_response_tx.sv
// tb_alu_response_tx: directed vector bench for alu_response_tx.
// Decodes sout bit by bit and compares frames and handshake timing.
module tb_alu_response_tx;

`ifdef ALU_TX_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_err;
  logic [31:0] tx_c;
  logic [3:0]  tx_flags;
  logic [2:0]  tx_err_flags;
  logic        sout;
  logic        tx_done;

  int n_checks = 0;
  int n_errors = 0;

  alu_response_tx dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_err       (tx_err),
    .tx_c         (tx_c),
    .tx_flags     (tx_flags),
    .tx_err_flags (tx_err_flags),
    .sout         (sout),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  ef;
    logic [7:0]  ctl;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic t,
                                          input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  // Waits (bounded) for tx_ready, then presents a request for one edge.
  // Returns 1ns after the accept edge with tx_valid still asserted.
  task automatic present(input logic err, input logic [31:0] c,
                         input logic [3:0] fl, input logic [2:0] ef,
                         output logic ok);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (tx_ready === 1'b1);
    chk("ready wait", {63'd0, tx_ready}, 64'd1);
    if (ok) begin
      tx_err       = err;
      tx_c         = c;
      tx_flags     = fl;
      tx_err_flags = ef;
      tx_valid     = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Called 1ns after the accept edge T.
  task automatic rx_resp(input string nm, input int nfr,
                         input logic [39:0] pl);
    logic        got[$];
    int          total;
    int          busy_bad;
    int          pos;
    logic [10:0] ef;
    logic [10:0] gf;
    logic        gap_ok;
    total    = (nfr == 1) ? 11 : 5 * 11 + 4 * GAP;
    busy_bad = 0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      got.push_back(sout);
      if (tx_ready !== 1'b0 || tx_done !== 1'b0) busy_bad++;
    end
    chk({nm, " busy"}, 64'(busy_bad), 64'd0);
    pos = 0;
    for (int f = 0; f < nfr; f++) begin
      gap_ok = 1'b1;
      if (f > 0)
        for (int g = 0; g < GAP; g++) begin
          if (got[pos] !== 1'b1) gap_ok = 1'b0;
          pos++;
        end
      if (nfr == 1) ef = mkframe(1'b1, pl[7:0]);
      else          ef = mkframe(f == 4, pl[39-8*f -: 8]);
      for (int b = 0; b < 11; b++) begin
        gf[10-b] = got[pos];
        pos++;
      end
      chk($sformatf("%s frame%0d", nm, f),
          {52'd0, gap_ok, gf}, {52'd0, 1'b1, ef});
    end
    @(posedge clk); #1;
    chk({nm, " done"}, {61'd0, tx_done, tx_ready, sout}, 64'd7);
    @(posedge clk); #1;
    chk({nm, " done pulse"}, {63'd0, tx_done}, 64'd0);
  endtask

  initial begin
    logic ok;
    int   dseen;
    int   sbad;

    vt[0] = '{"d3",     1'b0, 32'h0000_0003, 4'b0000, 3'b111, 8'h06};
    vt[1] = '{"e001",   1'b1, 32'hDEAD_BEEF, 4'b1111, 3'b001, 8'h93};
    vt[2] = '{"e100",   1'b1, 32'h1234_5678, 4'b0101, 3'b100, 8'hC9};
    vt[3] = '{"e010",   1'b1, 32'h0000_0000, 4'b0000, 3'b010, 8'hA5};
    vt[4] = '{"e111",   1'b1, 32'hFFFF_FFFF, 4'b1111, 3'b111, 8'hC9};
    vt[5] = '{"e000",   1'b1, 32'hA5A5_A5A5, 4'b0000, 3'b000, 8'h93};
    vt[6] = '{"dff",    1'b0, 32'hFFFF_FFFF, 4'b1001, 3'b000, 8'h4D};
    vt[7] = '{"dzero",  1'b0, 32'h0000_0000, 4'b0100, 3'b010, 8'h27};
    vt[8] = '{"dmsb",   1'b0, 32'h8000_0000, 4'b0000, 3'b001, 8'h06};

    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_err       = 1'b0;
    tx_c         = '0;
    tx_flags     = '0;
    tx_err_flags = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {61'd0, sout, tx_ready, tx_done}, 64'd6);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle %0d", i),
          {61'd0, sout, tx_ready, tx_done}, 64'd6);
    end

    for (int i = 0; i < 9; i++) begin
      present(vt[i].err, vt[i].c, vt[i].fl, vt[i].ef, ok);
      tx_valid = 1'b0;
      if (ok)
        rx_resp(vt[i].name, vt[i].err ? 1 : 5,
                {vt[i].err ? 32'h0 : vt[i].c, vt[i].ctl});
    end

    // valid held high, inputs churn during the response
    present(1'b0, 32'h8000_0000, 4'b0000, 3'b000, ok);
    if (ok) begin
      fork
        rx_resp("hold", 5, {32'h8000_0000, 8'h06});
        begin
          repeat (40) begin
            @(posedge clk); #2;
            tx_c     = $urandom;
            tx_flags = 4'($urandom);
          end
          tx_err       = 1'b1;
          tx_err_flags = 3'b010;
        end
      join
      chk("hold next accept", {62'd0, sout, tx_ready}, 64'd0);
      tx_valid = 1'b0;
      rx_resp("hold err", 1, {32'h0, 8'hA5});
    end

    // back-to-back: exactly one idle bit between responses
    present(1'b0, 32'hFFFF_FFFF, 4'b1001, 3'b000, ok);
    if (ok) begin
      tx_err       = 1'b1;
      tx_err_flags = 3'b100;
      tx_c         = 32'h0;
      rx_resp("b2b", 5, {32'hFFFF_FFFF, 8'h4D});
      chk("b2b next accept", {62'd0, sout, tx_ready}, 64'd0);
      tx_valid = 1'b0;
      rx_resp("b2b err", 1, {32'h0, 8'hC9});
    end

    // reset in the middle of a data response
    present(1'b0, 32'hA5A5_A5A5, 4'b0000, 3'b000, ok);
    tx_valid = 1'b0;
    if (ok) begin
      repeat (19) @(posedge clk);
      #1;
      chk("pre-rst bit19", {63'd0, sout}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst", {61'd0, sout, tx_ready, tx_done}, 64'd6);
      @(posedge clk); #1;
      rst   = 1'b0;
      dseen = 0;
      sbad  = 0;
      repeat (60) begin
        @(posedge clk); #1;
        if (tx_done !== 1'b0) dseen++;
        if (sout !== 1'b1) sbad++;
      end
      chk("rst no done", 64'(dseen), 64'd0);
      chk("rst sout idle", 64'(sbad), 64'd0);
      present(1'b1, 32'h0, 4'b0000, 3'b001, ok);
      tx_valid = 1'b0;
      if (ok) rx_resp("post-rst e001", 1, {32'h0, 8'h93});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
